// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matmul stream controller.
package matmul_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ACC_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned N_ELEM      = 9;
    localparam int unsigned N_OPER      = 18;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLR   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Slot k of a flattened element bus occupies bits [k*w +: w].
    function automatic int unsigned slot_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/matmul_stream_ctrl_if.sv
// Operand/result streams plus the systolic-core control bus.
interface matmul_stream_ctrl_if
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) ();

    logic                       in_valid_i;
    logic [DATA_W-1:0]          in_data_i;
    logic                       in_ready_o;
    logic                       out_valid_o;
    logic [ACC_W-1:0]           out_data_o;
    logic                       out_last_o;
    logic                       out_ready_i;
    logic                       core_rst_o;
    logic                       core_start_o;
    logic [N_ELEM*DATA_W-1:0]   core_a_o;
    logic [N_ELEM*DATA_W-1:0]   core_b_o;
    logic                       core_done_i;
    logic [N_ELEM*ACC_W-1:0]    core_c_i;
    logic                       busy_o;
    logic                       err_o;

    modport master (
        input  in_valid_i, in_data_i, out_ready_i, core_done_i, core_c_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o,
               core_rst_o, core_start_o, core_a_o, core_b_o, busy_o, err_o
    );

    modport slave (
        output in_valid_i, in_data_i, out_ready_i, core_done_i, core_c_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o,
               core_rst_o, core_start_o, core_a_o, core_b_o, busy_o, err_o
    );

endinterface

// File: rtl/matmul_stream_ctrl.sv
// Host-side initiator for the 3x3 systolic core: load 18 operands, clear,
// run with timeout, then stream the 9 results out with last on c9.
module matmul_stream_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ACC_W       = ACC_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    matmul_stream_ctrl_if.master  bus
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [TMO_W-1:0]                  tmo_q, tmo_d, tmo_inc;
    logic [N_ELEM-1:0][DATA_W-1:0]     a_q, a_d;
    logic [N_ELEM-1:0][DATA_W-1:0]     b_q, b_d;
    logic [N_ELEM-1:0][ACC_W-1:0]      res_q, res_d;
    logic                              in_ready_q, in_ready_d;
    logic                              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]                  out_data_q, out_data_d;
    logic                              out_last_q, out_last_d;
    logic                              core_rst_q, core_rst_d;
    logic                              core_start_q, core_start_d;
    logic                              busy_q, busy_d;
    logic                              err_q, err_d;
    logic                              in_acc, out_acc;

    assign in_acc  = bus.in_valid_i && in_ready_q;
    assign out_acc = out_valid_q && bus.out_ready_i;
    assign tmo_inc = tmo_q + TMO_W'(1);

    // Next state, datapath updates, and registered-output decode of the next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        err_d        = err_q;
        out_data_d   = out_data_q;
        in_ready_d   = 1'b0;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        core_rst_d   = 1'b0;
        core_start_d = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_acc) begin
                    for (int unsigned k = 0; k < N_ELEM; k++) begin
                        if (cnt_q == CNT_W'(k))          a_d[k] = bus.in_data_i;
                        if (cnt_q == CNT_W'(k + N_ELEM)) b_d[k] = bus.in_data_i;
                    end
                    if (cnt_q == CNT_W'(N_OPER - 1)) begin
                        state_d = CLR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CLR: begin
                // Done may still be high from the previous job; never sampled here.
                state_d = RUN;
                tmo_d   = '0;
            end
            RUN: begin
                if (bus.core_done_i) begin
                    for (int unsigned k = 0; k < N_ELEM; k++) begin
                        res_d[k] = bus.core_c_i[slot_lo(k, ACC_W) +: ACC_W];
                    end
                    state_d = DRAIN;
                    idx_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_inc == TMO_W'(TIMEOUT_CYC)) begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            DRAIN: begin
                if (out_acc) begin
                    if (idx_q == IDX_W'(N_ELEM - 1)) begin
                        state_d = LOAD;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
                idx_d   = '0;
                tmo_d   = '0;
            end
        endcase

        in_ready_d   = (state_d == LOAD);
        core_rst_d   = (state_d == CLR);
        core_start_d = (state_d == RUN);
        out_valid_d  = (state_d == DRAIN);
        out_last_d   = (state_d == DRAIN) && (idx_d == IDX_W'(N_ELEM - 1));
        busy_d       = !((state_d == LOAD) && (cnt_d == '0));
        if (state_d == DRAIN) begin
            for (int unsigned k = 0; k < N_ELEM; k++) begin
                if (idx_d == IDX_W'(k)) out_data_d = res_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            core_rst_q   <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            core_rst_q   <= core_rst_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready_o   = in_ready_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = out_data_q;
    assign bus.out_last_o   = out_last_q;
    assign bus.core_rst_o   = core_rst_q;
    assign bus.core_start_o = core_start_q;
    assign bus.core_a_o     = a_q;
    assign bus.core_b_o     = b_q;
    assign bus.busy_o       = busy_q;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed plus randomized bench for matmul_stream_ctrl with a behavioural core model.
module tb_matmul_stream_ctrl;

    localparam int CORE_L = 7;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_edge = -1;
    int   n_crst   = 0;
    int   n_oval   = 0;
    int   la       = 0;
    int   mode     = 0;  // 0 normal core, 1 hung core, 2 stale-done stub

    matmul_stream_ctrl_if #(.DATA_W(8), .ACC_W(16)) bus ();

    matmul_stream_ctrl #(.DATA_W(8), .ACC_W(16), .TIMEOUT_CYC(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural systolic core: product of the A/B buses, done after CORE_L start cycles.
    logic [143:0] c_q;
    logic         done_q;
    logic         pulse_q;
    int           ccnt;

    function automatic logic [143:0] core_prod(input logic [71:0] a, input logic [71:0] b);
        logic [143:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(a[(i*3+k)*8 +: 8]) * int'(b[(k*3+j)*8 +: 8]);
                r[(i*3+j)*16 +: 16] = 16'(s);
            end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst || bus.core_rst_o) begin
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            ccnt    <= 0;
            c_q     <= '0;
        end else if (bus.core_start_o) begin
            ccnt    <= ccnt + 1;
            c_q     <= core_prod(bus.core_a_o, bus.core_b_o);
            pulse_q <= (ccnt + 1 == 5);
            if (ccnt + 1 == CORE_L) done_q <= 1'b1;
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign bus.core_c_i    = c_q;
    assign bus.core_done_i = (mode == 0) ? done_q :
                             (mode == 1) ? 1'b0 : (bus.core_rst_o | pulse_q);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.core_rst_o) n_crst <= n_crst + 1;
        if (bus.out_valid_o) n_oval <= n_oval + 1;
        if (bus.core_done_i && bus.core_start_o) done_edge <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: C = A*B on the operand list, truncated to the result width.
    function automatic void ref_mm(input int ops[18], output int exp[9]);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int k = 0; k < 3; k++) s += ops[i*3+k] * ops[9+k*3+j];
                exp[i*3+j] = s & 16'hFFFF;
            end
    endfunction

    function automatic logic [71:0] pack8(input int ops[18], input int base);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(ops[base+k]);
        return r;
    endfunction

    task automatic push(input int d);
        int b = 0;
        while (!bus.in_ready_o && b < 200) begin @(negedge clk); b++; end
        if (b == 200) chk("in_ready_wait", {71'd0, bus.in_ready_o}, 72'd1);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'(d);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        la = cyc;
    endtask

    task automatic load(input int ops[18], input int n, input int gap_mode);
        for (int i = 0; i < n; i++) begin
            push(ops[i]);
            if (i != n - 1) begin
                int g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (g) @(negedge clk);
            end
        end
    endtask

    task automatic pull(input int exp[9], input int n, input int stall_idx, input int stall_len,
                        input int lat_mode, input logic [71:0] exp_a);
        for (int i = 0; i < n; i++) begin
            int b = 0;
            while (!bus.out_valid_o && b < 300) begin @(negedge clk); b++; end
            chk($sformatf("out_valid[%0d]", i), {71'd0, bus.out_valid_o}, 72'd1);
            if (i == 0) begin
                if (lat_mode == 1) chk("latency", 72'(cyc), 72'(la + CORE_L + 2));
                if (lat_mode == 2) chk("stale_lat", 72'(cyc), 72'(done_edge));
                chk("core_a", bus.core_a_o, exp_a);
            end
            chk($sformatf("out_data[%0d]", i), 72'(bus.out_data_o), 72'(exp[i]));
            chk($sformatf("out_last[%0d]", i), {71'd0, bus.out_last_o}, 72'(i == 8));
            if (i == stall_idx) begin
                bus.out_ready_i = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_data", 72'(bus.out_data_o), 72'(exp[i]));
                    chk("stall_valid", {71'd0, bus.out_valid_o}, 72'd1);
                end
                bus.out_ready_i = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_job(input int ops[18], input int exp[9], input int gap_mode,
                           input int stall_idx, input int stall_len, input int lat_mode,
                           input logic exp_err);
        int c0 = n_crst;
        load(ops, 18, gap_mode);
        pull(exp, 9, stall_idx, stall_len, lat_mode, pack8(ops, 0));
        chk("core_b", bus.core_b_o, pack8(ops, 9));
        chk("post_in_ready", {71'd0, bus.in_ready_o}, 72'd1);
        chk("post_out_valid", {71'd0, bus.out_valid_o}, 72'd0);
        chk("post_busy", {71'd0, bus.busy_o}, 72'd0);
        chk("err", {71'd0, bus.err_o}, 72'(exp_err));
        chk("crst_pulses", 72'(n_crst - c0), 72'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {71'd0, bus.in_ready_o},   72'd1);
        chk({tag, "_out_valid"}, {71'd0, bus.out_valid_o},  72'd0);
        chk({tag, "_out_last"},  {71'd0, bus.out_last_o},   72'd0);
        chk({tag, "_out_data"},  72'(bus.out_data_o),       72'd0);
        chk({tag, "_core_rst"},  {71'd0, bus.core_rst_o},   72'd0);
        chk({tag, "_start"},     {71'd0, bus.core_start_o}, 72'd0);
        chk({tag, "_busy"},      {71'd0, bus.busy_o},       72'd0);
        chk({tag, "_err"},       {71'd0, bus.err_o},        72'd0);
        chk({tag, "_core_a"},    bus.core_a_o,              72'd0);
    endtask

    initial begin
        int ops1[18];
        int ops3[18];
        int exp1[9] = '{84, 90, 96, 201, 216, 231, 318, 342, 366};
        int exp3[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int rops[18];
        int rexp[9];
        int o0;

        for (int i = 0; i < 18; i++) ops1[i] = i + 1;
        for (int i = 0; i < 9; i++) begin
            ops3[i]     = (i % 4 == 0) ? 1 : 0;
            ops3[9 + i] = i + 1;
        end

        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Basic job, then gaps with backpressure, then back-to-back with identity A.
        run_job(ops1, exp1, 0, -1, 0, 1, 1'b0);
        run_job(ops1, exp1, 1, 4, 3, 0, 1'b0);
        run_job(ops3, exp3, 0, -1, 0, 1, 1'b0);

        // Reset mid-load, then a clean job.
        load(ops1, 7, 0);
        chk("busy_mid_load", {71'd0, bus.busy_o}, 72'd1);
        do_reset();
        chk_reset_vals("rst_load");
        run_job(ops1, exp1, 0, -1, 0, 1, 1'b0);

        // Reset at drain index 3, then a clean job.
        load(ops1, 18, 0);
        pull(exp1, 3, -1, 0, 0, pack8(ops1, 0));
        do_reset();
        chk_reset_vals("rst_drain");
        run_job(ops1, exp1, 0, -1, 0, 1, 1'b0);

        // Stale done held through CLR, real done pulse later in RUN.
        mode = 2;
        run_job(ops1, exp1, 0, -1, 0, 2, 1'b0);

        // Hung core: timeout, sticky error through a good job, cleared by reset.
        mode = 1;
        o0 = n_oval;
        load(ops1, 18, 0);
        while (cyc < la + 64) @(negedge clk);
        chk("tmo_err_before", {71'd0, bus.err_o}, 72'd0);
        chk("tmo_ready_before", {71'd0, bus.in_ready_o}, 72'd0);
        @(negedge clk);
        chk("tmo_err", {71'd0, bus.err_o}, 72'd1);
        chk("tmo_ready", {71'd0, bus.in_ready_o}, 72'd1);
        chk("tmo_busy", {71'd0, bus.busy_o}, 72'd0);
        chk("tmo_no_output", 72'(n_oval - o0), 72'd0);
        mode = 0;
        run_job(ops1, exp1, 0, -1, 0, 1, 1'b1);
        do_reset();
        chk_reset_vals("rst_err");

        // Randomized jobs against the reference model.
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 18; i++) rops[i] = int'($urandom_range(0, 255));
            ref_mm(rops, rexp);
            run_job(rops, rexp, 2, int'($urandom_range(0, 8)), int'($urandom_range(1, 4)), 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
